// File: rtl/lock_pkg.sv
// Shared types and display constants for the combination lock (programmer and checker).
package lock_pkg;

  localparam int NUM_DIGITS = 6;

  typedef logic [4*NUM_DIGITS-1:0] code_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ENTER   = 3'd1,
    ST_CONFIRM = 3'd2,
    ST_DONE    = 3'd3,
    ST_ERR     = 3'd4
  } state_t;

  localparam logic [3:0] MAX_DIGIT = 4'd9;

  // Active-low 7-segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_S     = 7'b0010010;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_T     = 7'b0000111;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_O_LC  = 7'b0100011;
  localparam logic [6:0] SEG_N     = 7'b0101011;
  localparam logic [6:0] SEG_R     = 7'b0101111;
  localparam logic [6:0] SEG_O_UC  = 7'b1000000;

endpackage

// File: rtl/seg7_digit.sv
// Decimal digit to active-low 7-segment pattern; anything above 9 shows blank.
module seg7_digit
  import lock_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (value)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/combo_programmer.sv
// Two-pass (enter, confirm) programming of the 6-digit lock combination with
// progress / done / error messages on the six HEX displays.
module combo_programmer
  import lock_pkg::*;
#(
  parameter code_t DEFAULT_CODE = 24'h511748
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        clear,
  input  logic        digit_valid,
  input  logic [3:0]  digit,
  output logic [23:0] code_out,
  output logic        code_update,
  output logic        busy,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5
);

  localparam logic [2:0] LAST_IDX = 3'(NUM_DIGITS - 1);

  state_t      state_reg;
  logic [2:0]  idx_reg;
  logic        mismatch_reg;
  logic [3:0]  staged_reg [NUM_DIGITS];
  code_t       code_out_reg;
  logic        code_update_reg;

  code_t       staged_code;
  logic        digit_legal;
  logic        digit_neq;
  logic [6:0]  idx_seg;

  // Digit 1 (idx 0) lands in the most significant nibble
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_pack
      assign staged_code[4*(NUM_DIGITS-1-gi) +: 4] = staged_reg[gi];
    end
  endgenerate

  assign digit_legal = (digit <= MAX_DIGIT);
  assign digit_neq   = (digit != staged_reg[idx_reg]);

  always_ff @(posedge clk) begin
    code_update_reg <= 1'b0;
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      idx_reg      <= '0;
      mismatch_reg <= 1'b0;
      code_out_reg <= DEFAULT_CODE;
      for (int i = 0; i < NUM_DIGITS; i++) staged_reg[i] <= '0;
    end else if (start) begin
      state_reg    <= ST_ENTER;
      idx_reg      <= '0;
      mismatch_reg <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) staged_reg[i] <= '0;
    end else if (clear && (state_reg == ST_DONE || state_reg == ST_ERR)) begin
      state_reg <= ST_IDLE;
    end else if (digit_valid) begin
      case (state_reg)
        ST_ENTER: begin
          if (!digit_legal) begin
            state_reg <= ST_ERR;
          end else begin
            staged_reg[idx_reg] <= digit;
            if (idx_reg == LAST_IDX) begin
              state_reg <= ST_CONFIRM;
              idx_reg   <= '0;
            end else begin
              idx_reg <= idx_reg + 3'd1;
            end
          end
        end
        ST_CONFIRM: begin
          if (!digit_legal) begin
            state_reg <= ST_ERR;
          end else begin
            // Mismatches accumulate silently so the failing position stays hidden
            mismatch_reg <= mismatch_reg | digit_neq;
            if (idx_reg == LAST_IDX) begin
              if (mismatch_reg | digit_neq) begin
                state_reg <= ST_ERR;
              end else begin
                state_reg       <= ST_DONE;
                code_out_reg    <= staged_code;
                code_update_reg <= 1'b1;
              end
            end else begin
              idx_reg <= idx_reg + 3'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign code_out    = code_out_reg;
  assign code_update = code_update_reg;
  assign busy        = (state_reg == ST_ENTER) || (state_reg == ST_CONFIRM);

  seg7_digit u_idx_seg (
    .value ({1'b0, idx_reg}),
    .seg   (idx_seg)
  );

  always_comb begin
    hex0 = SEG_BLANK;
    hex1 = SEG_BLANK;
    hex2 = SEG_BLANK;
    hex3 = SEG_BLANK;
    hex4 = SEG_BLANK;
    hex5 = SEG_BLANK;
    case (state_reg)
      ST_IDLE: begin
        hex5 = SEG_S;
        hex4 = SEG_E;
        hex3 = SEG_T;
      end
      ST_ENTER: begin
        hex5 = SEG_E;
        hex0 = idx_seg;
      end
      ST_CONFIRM: begin
        hex5 = SEG_C;
        hex0 = idx_seg;
      end
      ST_DONE: begin
        hex3 = SEG_D;
        hex2 = SEG_O_LC;
        hex1 = SEG_N;
        hex0 = SEG_E;
      end
      ST_ERR: begin
        hex4 = SEG_E;
        hex3 = SEG_R;
        hex2 = SEG_R;
        hex1 = SEG_O_UC;
        hex0 = SEG_R;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_combo_programmer.sv
// Self-checking bench for combo_programmer: vector table, directed corner cases, random vs. queue model.
module tb_combo_programmer;

  logic        clk = 1'b0;
  logic        rst_n, start, clear, digit_valid;
  logic [3:0]  digit;
  logic [23:0] code_out;
  logic        code_update, busy;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;

  int n_vec = 0;
  int n_mis = 0;
  int n_txn = 0;

  localparam logic [23:0] DEF = 24'h511748;
  localparam logic [6:0] BL = 7'b1111111, L_S = 7'b0010010, L_E = 7'b0000110,
                         L_T = 7'b0000111, L_C = 7'b1000110, L_D = 7'b0100001,
                         L_O = 7'b0100011, L_N = 7'b0101011, L_R = 7'b0101111,
                         L_OO = 7'b1000000;
  localparam int M_IDLE = 0, M_ENTER = 1, M_CONF = 2, M_DONE = 3, M_ERR = 4;

  combo_programmer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
    .digit_valid(digit_valid), .digit(digit),
    .code_out(code_out), .code_update(code_update), .busy(busy),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5)
  );

  always #5 clk = ~clk;

  // Reference model: what the user has typed so far, as plain queues
  int          m_mode;
  logic [3:0]  ent_q[$];
  logic [3:0]  conf_q[$];
  logic [23:0] m_code;
  bit          m_upd;

  function automatic logic [6:0] dec7(int v);
    logic [6:0] t [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                          7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    return (v >= 0 && v <= 9) ? t[v] : BL;
  endfunction

  function automatic logic [41:0] disp(int mode, int pos);
    case (mode)
      M_IDLE:  return {L_S, L_E, L_T, BL, BL, BL};
      M_ENTER: return {L_E, BL, BL, BL, BL, dec7(pos)};
      M_CONF:  return {L_C, BL, BL, BL, BL, dec7(pos)};
      M_DONE:  return {BL, BL, L_D, L_O, L_N, L_E};
      default: return {BL, L_E, L_R, L_R, L_OO, L_R};
    endcase
  endfunction

  function automatic void model_step(bit r, bit s, bit c, bit v, logic [3:0] d);
    m_upd = 0;
    if (!r) begin
      m_mode = M_IDLE; ent_q.delete(); conf_q.delete(); m_code = DEF;
    end else if (s) begin
      m_mode = M_ENTER; ent_q.delete(); conf_q.delete();
    end else if (c && (m_mode == M_DONE || m_mode == M_ERR)) begin
      m_mode = M_IDLE;
    end else if (v && (m_mode == M_ENTER || m_mode == M_CONF)) begin
      if (d > 9) m_mode = M_ERR;
      else if (m_mode == M_ENTER) begin
        ent_q.push_back(d);
        if (ent_q.size() == 6) m_mode = M_CONF;
      end else begin
        conf_q.push_back(d);
        if (conf_q.size() == 6) begin
          bit same = 1;
          for (int i = 0; i < 6; i++) if (conf_q[i] != ent_q[i]) same = 0;
          if (same) begin
            m_code = 0;
            for (int i = 0; i < 6; i++) m_code = (m_code << 4) | 24'(ent_q[i]);
            m_upd = 1; m_mode = M_DONE;
          end else m_mode = M_ERR;
        end
      end
    end
  endfunction

  function automatic int m_pos();
    return (m_mode == M_ENTER) ? ent_q.size() : conf_q.size();
  endfunction

  task automatic cmp(string name, logic [41:0] act, logic [41:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [41:0] hex_all();
    return {hex5, hex4, hex3, hex2, hex1, hex0};
  endfunction

  task automatic check_model(string name);
    cmp({name, ".code"}, 42'(code_out), 42'(m_code));
    cmp({name, ".upd"},  42'(code_update), 42'(m_upd));
    cmp({name, ".busy"}, 42'(busy), 42'(m_mode == M_ENTER || m_mode == M_CONF));
    cmp({name, ".hex"},  hex_all(), disp(m_mode, m_pos()));
  endtask

  task automatic apply(bit r, bit s, bit c, bit v, logic [3:0] d, bit chk, string name);
    rst_n = r; start = s; clear = c; digit_valid = v; digit = d;
    @(posedge clk);
    model_step(r, s, c, v, d);
    #1;
    n_txn++;
    $display("txn %0d %s rst_n=%0b st=%0b cl=%0b dv=%0b d=%h -> code=%h upd=%0b busy=%0b hex=%h",
             n_txn, name, r, s, c, v, d, code_out, code_update, busy, hex_all());
    if (chk) check_model(name);
  endtask

  task automatic digits(logic [3:0] a, logic [3:0] b, logic [3:0] c, logic [3:0] d4,
                        logic [3:0] e, logic [3:0] f, string name);
    logic [3:0] s [6];
    s = '{a, b, c, d4, e, f};
    for (int i = 0; i < 6; i++) apply(1, 0, 0, 1, s[i], 1, name);
  endtask

  typedef struct {
    bit          s;
    bit          v;
    logic [3:0]  d;
    logic [23:0] ecode;
    bit          eupd;
    bit          ebusy;
    logic [41:0] ehex;
  } vec_t;

  vec_t tbl [14];

  initial begin
    logic [3:0] pi [6];
    pi = '{4'd3, 4'd1, 4'd4, 4'd1, 4'd5, 4'd9};
    rst_n = 0; start = 0; clear = 0; digit_valid = 0; digit = 0;
    m_mode = M_IDLE; m_code = DEF; m_upd = 0;

    // Test 1 as a table: start, 6 enter digits, 6 confirm digits, one idle cycle
    tbl[0] = '{1, 0, 4'd0, DEF, 0, 1, disp(M_ENTER, 0)};
    for (int i = 0; i < 6; i++)
      tbl[1+i] = '{0, 1, pi[i], DEF, 0, 1, (i < 5) ? disp(M_ENTER, i+1) : disp(M_CONF, 0)};
    for (int i = 0; i < 6; i++)
      tbl[7+i] = '{0, 1, pi[i], (i < 5) ? DEF : 24'h314159, (i == 5), (i < 5),
                   (i < 5) ? disp(M_CONF, i+1) : disp(M_DONE, 0)};
    tbl[13] = '{0, 0, 4'd0, 24'h314159, 0, 0, disp(M_DONE, 0)};

    apply(0, 0, 0, 0, 0, 0, "reset");
    cmp("reset.code", 42'(code_out), 42'(DEF));
    cmp("reset.upd", 42'(code_update), 42'd0);
    cmp("reset.busy", 42'(busy), 42'd0);
    cmp("reset.hex", hex_all(), {L_S, L_E, L_T, BL, BL, BL});

    for (int i = 0; i < 14; i++) begin
      apply(1, tbl[i].s, 0, tbl[i].v, tbl[i].d, 0, "tbl");
      cmp($sformatf("tbl%0d.code", i), 42'(code_out), 42'(tbl[i].ecode));
      cmp($sformatf("tbl%0d.upd", i), 42'(code_update), 42'(tbl[i].eupd));
      cmp($sformatf("tbl%0d.busy", i), 42'(busy), 42'(tbl[i].ebusy));
      cmp($sformatf("tbl%0d.hex", i), hex_all(), tbl[i].ehex);
    end

    // Test 2: late mismatch only reported after the sixth confirm digit
    apply(0, 0, 0, 0, 0, 1, "t2.rst");
    apply(1, 1, 0, 0, 0, 1, "t2.start");
    digits(3, 1, 4, 1, 5, 9, "t2.ent");
    digits(3, 1, 4, 1, 5, 8, "t2.conf");
    cmp("t2.code_kept", 42'(code_out), 42'(DEF));
    cmp("t2.err_hex", hex_all(), {BL, L_E, L_R, L_R, L_OO, L_R});

    // Test 3: illegal digit aborts on that edge; restart shows idx 0
    apply(1, 1, 0, 0, 0, 1, "t3.start");
    apply(1, 0, 0, 1, 4'd3, 1, "t3.d1");
    apply(1, 0, 0, 1, 4'd1, 1, "t3.d2");
    apply(1, 0, 0, 1, 4'hC, 1, "t3.bad");
    apply(1, 0, 0, 1, 4'd2, 1, "t3.ignored");
    apply(1, 1, 0, 0, 0, 1, "t3.restart");
    cmp("t3.hex0", 42'(hex0), 42'(7'b1000000));

    // Test 4: restart mid-entry discards the partial digits
    apply(1, 0, 0, 1, 4'd7, 1, "t4.p");
    apply(1, 0, 0, 1, 4'd8, 1, "t4.p");
    apply(1, 0, 0, 1, 4'd9, 1, "t4.p");
    apply(1, 0, 0, 1, 4'd6, 1, "t4.p");
    apply(1, 1, 0, 0, 0, 1, "t4.restart");
    digits(2, 2, 2, 2, 2, 2, "t4.ent");
    digits(2, 2, 2, 2, 2, 2, "t4.conf");
    cmp("t4.code", 42'(code_out), 42'h222222);

    // Test 5: reset in CONFIRM at idx 3
    apply(1, 0, 0, 0, 0, 1, "t5.idle");
    apply(1, 1, 0, 0, 0, 1, "t5.start");
    digits(1, 2, 3, 4, 5, 6, "t5.ent");
    apply(1, 0, 0, 1, 4'd1, 1, "t5.c");
    apply(1, 0, 0, 1, 4'd2, 1, "t5.c");
    apply(1, 0, 0, 1, 4'd3, 1, "t5.c");
    apply(0, 0, 0, 1, 4'd4, 1, "t5.rst");
    cmp("t5.code", 42'(code_out), 42'(DEF));
    cmp("t5.upd", 42'(code_update), 42'd0);
    cmp("t5.hex", hex_all(), {L_S, L_E, L_T, BL, BL, BL});

    // Test 6: idle gaps mid-entry, then start+clear together in DONE
    apply(1, 1, 0, 0, 0, 1, "t6.start");
    apply(1, 0, 0, 1, 4'd0, 1, "t6.e");
    apply(1, 0, 0, 1, 4'd9, 1, "t6.e");
    for (int i = 0; i < 5; i++) apply(1, 0, 0, 0, 4'd5, 1, "t6.gap");
    cmp("t6.idx_held", 42'(hex0), 42'(7'b0100100));
    apply(1, 0, 0, 1, 4'd0, 1, "t6.e");
    apply(1, 0, 0, 1, 4'd9, 1, "t6.e");
    apply(1, 0, 0, 1, 4'd0, 1, "t6.e");
    apply(1, 0, 0, 1, 4'd9, 1, "t6.e");
    digits(0, 9, 0, 9, 0, 9, "t6.conf");
    cmp("t6.code", 42'(code_out), 42'h090909);
    apply(1, 1, 1, 0, 0, 1, "t6.start_clear");
    cmp("t6.enter", hex_all(), {L_E, BL, BL, BL, BL, 7'b1000000});

    // Random traffic against the queue model; confirm digits often replay the entry
    for (int n = 0; n < 1500; n++) begin
      bit r, s, c, v;
      logic [3:0] d;
      r = ($urandom_range(0, 199) != 0);
      s = ($urandom_range(0, 29) == 0);
      v = ($urandom_range(0, 3) != 0);
      c = !v && ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 24) == 0) d = 4'($urandom_range(10, 15));
      else if (m_mode == M_CONF && $urandom_range(0, 9) != 0) d = ent_q[conf_q.size()];
      else d = 4'($urandom_range(0, 9));
      apply(r, s, c, v, d, 1, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/combo_programmer.md
Name: combo_programmer

Overview:
- Programming side of the switch/KEY combination lock: the user enters a new 6-digit combination twice (enter, then confirm).
- On an exact match, the block commits the code and publishes it to the lock's checker.
- It drives the six HEX displays with progress, "donE" and "ErrOr" messages.
- It sits beside the checker in the lab top level, sharing clk (from ~KEY[0]) and the switch digit source.

Parameters:
DEFAULT_CODE, 24'h511748, code loaded at reset; 6 BCD nibbles, digit 1 in [23:20], digit 6 in [3:0]
NUM_DIGITS, 6, digits per code; fixed at 6 (display and width assume 6)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous, active-low reset
start  input  1  begin (or restart) programming
clear  input  1  return from DONE/ERR to IDLE
digit_valid  input  1  digit is presented this cycle
digit  input  4  digit value; legal range 0..9
code_out  output  24  committed combination, BCD, digit 1 in MS nibble
code_update  output  1  one-cycle pulse when code_out changes
busy  output  1  high in ENTER or CONFIRM
hex0..hex5  output  7 each  active-low 7-seg, bit order {g,f,e,d,c,b,a}

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-low on rst_n.
- Reset values: state=IDLE, idx=0, staged=0, mismatch=0, code_out=DEFAULT_CODE, code_update=0.
- rst_n low overrides every other input, including mid-entry; staged digits are discarded and code_out returns to DEFAULT_CODE.
- States: IDLE, ENTER, CONFIRM, DONE, ERR. idx is a 3-bit count, 0..5.
- Input priority each edge: rst_n, then start, then clear, then digit_valid.
- start (any state): go to ENTER with idx=0, staged=0, mismatch=0. A restart mid-entry discards partial input.
- clear: from DONE or ERR go to IDLE. Ignored in other states.
- ENTER, digit_valid, digit<=9: staged[idx]<=digit. If idx==5, go to CONFIRM with idx=0; otherwise idx++.
- ENTER/CONFIRM, digit_valid, digit>9: go to ERR immediately.
- CONFIRM, digit_valid, digit<=9:
  - mismatch <= mismatch | (digit != staged[idx]).
  - If idx==5: final mismatch is mismatch | (digit != staged[5]).
  - Final mismatch clear: code_out<=staged, code_update=1 for one cycle, go to DONE.
  - Final mismatch set: go to ERR; code_out unchanged.
- A mismatch never aborts early; all 6 confirm digits are always consumed, so the failing position is not revealed.
- digit_valid low: no change. IDLE/DONE/ERR ignore digit_valid.
- code_out is registered and changes only on commit or reset. The checker keeps using the old code throughout programming.
- busy is combinational from state.
- Display is combinational from state and idx (zero latency); blank = 7'b1111111.
  - IDLE: hex5..hex3 = "SEt" (5 pattern, E, t=0000111); others blank.
  - ENTER: hex5=E.
  - CONFIRM: hex5=C (1000110).
  - ENTER and CONFIRM: hex0 = idx as a decimal digit; others blank. Entered digits are never displayed.
  - DONE: hex3..hex0 = d(0100001), o(0100011), n(0101011), E(0000110); hex5, hex4 blank.
  - ERR: hex5 blank; hex4..hex0 = E, r(0101111), r, O(1000000), r.

Decomposition:
- Package lock_pkg:
  - state enum (IDLE, ENTER, CONFIRM, DONE, ERR);
  - 7-seg letter/blank constants;
  - NUM_DIGITS;
  - the BCD code typedef (logic [23:0]).
  The checker shares this package.
- Sub-module seg7_digit (4-bit value to active-low segments; values >9 map to blank), reused by the checker.
- The FSM and staging register stay in combo_programmer.

Test Plan:
1. Reset, then start, enter 3,1,4,1,5,9, confirm 3,1,4,1,5,9 -> code_update pulses exactly one cycle after the 12th digit; code_out=24'h314159; display "donE".
2. Enter 3,1,4,1,5,9, confirm 3,1,4,1,5,8 -> ERR only after the 6th confirm digit (busy high through it); code_out stays 24'h511748; display "ErrOr".
3. Enter digit 4'hC as the 3rd ENTER digit -> ERR on that edge; a further start returns to ENTER with hex0=0.
4. After 4 ENTER digits assert start, then enter and confirm 2,2,2,2,2,2 -> code_out=24'h222222; the earlier partial digits have no effect.
5. rst_n low in CONFIRM at idx=3 -> next edge: IDLE, "SEt" displayed, code_out=DEFAULT_CODE, no code_update.
6. digit_valid held low for 5 cycles mid-ENTER, and start/clear asserted together in DONE -> idx unchanged while digit_valid is low; start wins and the block enters ENTER.
